// File: rtl/cpu_pkg.sv
// Shared widths and control-bundle layout for the pipelined CPU.
// Control bundle order: {RegWrite,MemtoReg,MemRead,MemWrite,ALUOp[1:0],ALUSrc,Branch}.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUOP_HI = 3;
  localparam int CTRL_ALUOP_LO = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_BRANCH   = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_wb_bypass.sv
// Write-back read-during-write bypass for one source operand.
// The register file returns stale data when WB writes the same index this cycle.
module wb_bypass
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic hit;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign hit      = wb_regwrite && (wb_rd != '0) && (wb_rd == rs_addr);
  assign fwd_data = hit ? wb_data : rs_data;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with WB bypass, stall hold and stall-safe flush.
// Optional performance counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CTRL_W = cpu_pkg::CTRL_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic              flush_pending_o
);

  logic              pend_flush;
  logic              do_bubble;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;

  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs1_bypass (
    .rs_addr     (rs1_addr_i),
    .rs_data     (rs1_data_i),
    .wb_regwrite (wb_regwrite_i),
    .wb_rd       (wb_rd_i),
    .wb_data     (wb_data_i),
    .fwd_data    (rs1_fwd)
  );

  wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs2_bypass (
    .rs_addr     (rs2_addr_i),
    .rs_data     (rs2_data_i),
    .wb_regwrite (wb_regwrite_i),
    .wb_rd       (wb_rd_i),
    .wb_data     (wb_data_i),
    .fwd_data    (rs2_fwd)
  );

  assign do_bubble       = !stall_i && (flush_i || pend_flush);
  assign flush_pending_o = pend_flush;

  // Stall outranks flush; a flush seen while frozen is parked until release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_flush <= 1'b0;
      valid_o    <= 1'b0;
      ctrl_o     <= CTRL_NOP;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      funct_o    <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      rd_addr_o  <= '0;
    end else if (stall_i) begin
      if (flush_i) begin
        pend_flush <= 1'b1;
      end
    end else if (do_bubble) begin
      pend_flush <= 1'b0;
      valid_o    <= 1'b0;
      ctrl_o     <= CTRL_NOP;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      funct_o    <= '0;
      rs1_addr_o <= '0;
      rs2_addr_o <= '0;
      rd_addr_o  <= '0;
    end else begin
      valid_o    <= valid_i;
      ctrl_o     <= valid_i ? ctrl_i : CTRL_NOP;
      rs1_data_o <= rs1_fwd;
      rs2_data_o <= rs2_fwd;
      imm_o      <= imm_i;
      funct_o    <= funct_i;
      rs1_addr_o <= rs1_addr_i;
      rs2_addr_o <= rs2_addr_i;
      rd_addr_o  <= rd_addr_i;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // A capture of an invalid instruction also counts as a bubble entering EX.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (stall_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (!stall_i && (do_bubble || !valid_i) && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg.
// Counter checks are compiled in only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_i;
  logic [7:0]  ctrl_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, wb_data_i;
  logic [9:0]  funct_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_i;
  logic        wb_regwrite_i;
  logic        valid_o, flush_pending_o;
  logic [7:0]  ctrl_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] bubble_cnt_o, stall_cnt_o;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  id_ex_stage_reg dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .valid_i         (valid_i),
    .ctrl_i          (ctrl_i),
    .rs1_data_i      (rs1_data_i),
    .rs2_data_i      (rs2_data_i),
    .imm_i           (imm_i),
    .funct_i         (funct_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rd_addr_i       (rd_addr_i),
    .wb_regwrite_i   (wb_regwrite_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .valid_o         (valid_o),
    .ctrl_o          (ctrl_o),
    .rs1_data_o      (rs1_data_o),
    .rs2_data_o      (rs2_data_o),
    .imm_o           (imm_o),
    .funct_o         (funct_o),
    .rs1_addr_o      (rs1_addr_o),
    .rs2_addr_o      (rs2_addr_o),
    .rd_addr_o       (rd_addr_o),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt_o    (bubble_cnt_o),
    .stall_cnt_o     (stall_cnt_o),
`endif
    .flush_pending_o (flush_pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle before sampling.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_instr(input logic [7:0] c, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
    valid_i = 1'b1; ctrl_i = c; rs1_data_i = d1; rs2_data_i = d2;
    rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd;
    imm_i = 32'h0000_0033; funct_i = 10'h02A;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; wb_regwrite_i = 1'b0;
    wb_rd_i = 5'd0; wb_data_i = 32'h0;
    load_instr(8'h00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    cycle(); cycle();
    check_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0h want 0", valid_o); else pass_cnt++;
    check_cnt++; if (ctrl_o !== 8'h00) $display("[TB] FAIL reset_ctrl: got %0h want 0", ctrl_o); else pass_cnt++;
    check_cnt++; if (rs1_data_o !== 32'h0) $display("[TB] FAIL reset_rs1: got %0h want 0", rs1_data_o); else pass_cnt++;
    check_cnt++; if (flush_pending_o !== 1'b0) $display("[TB] FAIL reset_pend: got %0h want 0", flush_pending_o); else pass_cnt++;
    rst_i = 1'b1;
  endtask

  task automatic test_plain_flush();
    load_instr(8'h81, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3);
    cycle();
    check_cnt++; if (valid_o !== 1'b1) $display("[TB] FAIL pf_pre_valid: got %0h want 1", valid_o); else pass_cnt++;
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL pf_valid: got %0h want 0", valid_o); else pass_cnt++;
    check_cnt++; if (ctrl_o !== 8'h00) $display("[TB] FAIL pf_ctrl: got %0h want 0", ctrl_o); else pass_cnt++;
    check_cnt++; if ({rs1_addr_o, rs2_addr_o, rd_addr_o} !== 15'h0)
      $display("[TB] FAIL pf_addrs: got %0h want 0", {rs1_addr_o, rs2_addr_o, rd_addr_o}); else pass_cnt++;
    check_cnt++; if (rs1_data_o !== 32'h0) $display("[TB] FAIL pf_data: got %0h want 0", rs1_data_o); else pass_cnt++;
`ifdef ID_EX_PERF_CNT_EN
    check_cnt++; if (bubble_cnt_o !== 16'd1) $display("[TB] FAIL pf_bubble_cnt: got %0d want 1", bubble_cnt_o); else pass_cnt++;
`endif
  endtask

  task automatic test_capture();
    load_instr(8'hA5, 32'h11, 32'h22, 5'd3, 5'd4, 5'd7);
    cycle();
    check_cnt++; if (valid_o !== 1'b1) $display("[TB] FAIL cap_valid: got %0h want 1", valid_o); else pass_cnt++;
    check_cnt++; if (ctrl_o !== 8'hA5) $display("[TB] FAIL cap_ctrl: got %0h want a5", ctrl_o); else pass_cnt++;
    check_cnt++; if (rs1_data_o !== 32'h11) $display("[TB] FAIL cap_rs1: got %0h want 11", rs1_data_o); else pass_cnt++;
    check_cnt++; if (rs2_data_o !== 32'h22) $display("[TB] FAIL cap_rs2: got %0h want 22", rs2_data_o); else pass_cnt++;
    check_cnt++; if ({rs1_addr_o, rs2_addr_o, rd_addr_o} !== {5'd3, 5'd4, 5'd7})
      $display("[TB] FAIL cap_addrs: got %0h want %0h", {rs1_addr_o, rs2_addr_o, rd_addr_o}, {5'd3, 5'd4, 5'd7}); else pass_cnt++;
    check_cnt++; if ({imm_o, funct_o} !== {32'h33, 10'h02A})
      $display("[TB] FAIL cap_imm_funct: got %0h want %0h", {imm_o, funct_o}, {32'h33, 10'h02A}); else pass_cnt++;
    // Invalid instruction: control zeroed, data still copied
    load_instr(8'hFF, 32'h77, 32'h88, 5'd9, 5'd10, 5'd11);
    valid_i = 1'b0;
    cycle();
    check_cnt++; if (valid_o !== 1'b0) $display("[TB] FAIL inv_valid: got %0h want 0", valid_o); else pass_cnt++;
    check_cnt++; if (ctrl_o !== 8'h00) $display("[TB] FAIL inv_ctrl: got %0h want 0", ctrl_o); else pass_cnt++;
    check_cnt++; if (rs1_data_o !== 32'h77) $display("[TB] FAIL inv_rs1: got %0h want 77", rs1_data_o); else pass_cnt++;
  endtask

  task automatic test_bypass();
    load_instr(8'h80, 32'h1, 32'h2, 5'd5, 5'd5, 5'd1);
    wb_regwrite_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD;
    cycle();
    check_cnt++; if (rs1_data_o !== 32'hDEAD) $display("[TB] FAIL byp_rs1: got %0h want dead", rs1_data_o); else pass_cnt++;
    check_cnt++; if (rs2_data_o !== 32'hDEAD) $display("[TB] FAIL byp_rs2: got %0h want dead", rs2_data_o); else pass_cnt++;
    load_instr(8'h80, 32'h1, 32'h2, 5'd0, 5'd6, 5'd1);
    wb_rd_i = 5'd0;
    cycle();
    check_cnt++; if (rs1_data_o !== 32'h1) $display("[TB] FAIL byp_x0: got %0h want 1", rs1_data_o); else pass_cnt++;
    wb_rd_i = 5'd6;
    load_instr(8'h80, 32'h3, 32'h4, 5'd5, 5'd6, 5'd1);
    cycle();
    check_cnt++; if ({rs1_data_o, rs2_data_o} !== {32'h3, 32'hDEAD})
      $display("[TB] FAIL byp_rs2_only: got %0h want %0h", {rs1_data_o, rs2_data_o}, {32'h3, 32'hDEAD}); else pass_cnt++;
    wb_regwrite_i = 1'b0;
    cycle();
    check_cnt++; if (rs2_data_o !== 32'h4) $display("[TB] FAIL byp_nowrite: got %0h want 4", rs2_data_o); else pass_cnt++;
  endtask

  task automatic test_stall_hold();
    load_instr(8'h3C, 32'h1234, 32'h5678, 5'd8, 5'd12, 5'd9);
    cycle();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_instr(8'hC0 + 8'(i), 32'hF000 + 32'(i), 32'hE000, 5'd8, 5'd13, 5'd14);
      wb_regwrite_i = 1'b1; wb_rd_i = 5'd8; wb_data_i = 32'hBEEF;
      cycle();
      check_cnt++; if ({valid_o, ctrl_o, rs1_data_o, rd_addr_o} !== {1'b1, 8'h3C, 32'h1234, 5'd9})
        $display("[TB] FAIL stall_hold%0d: got %0h want %0h", i, {valid_o, ctrl_o, rs1_data_o, rd_addr_o},
                 {1'b1, 8'h3C, 32'h1234, 5'd9}); else pass_cnt++;
    end
    stall_i = 1'b0; wb_regwrite_i = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    check_cnt++; if (stall_cnt_o !== 16'd4) $display("[TB] FAIL stall_cnt: got %0d want 4", stall_cnt_o); else pass_cnt++;
`endif
  endtask

  task automatic test_flush_in_stall();
    load_instr(8'h90, 32'hAA, 32'hBB, 5'd2, 5'd3, 5'd4);
    cycle();
    stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check_cnt++; if (flush_pending_o !== 1'b1) $display("[TB] FAIL fis_pend_set: got %0h want 1", flush_pending_o); else pass_cnt++;
    check_cnt++; if (valid_o !== 1'b1) $display("[TB] FAIL fis_hold_valid: got %0h want 1", valid_o); else pass_cnt++;
    cycle();
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check_cnt++; if (flush_pending_o !== 1'b1) $display("[TB] FAIL fis_pend_keep: got %0h want 1", flush_pending_o); else pass_cnt++;
    stall_i = 1'b0;
    cycle();
    check_cnt++; if ({valid_o, ctrl_o, rs1_addr_o} !== 14'h0)
      $display("[TB] FAIL fis_bubble: got %0h want 0", {valid_o, ctrl_o, rs1_addr_o}); else pass_cnt++;
    check_cnt++; if (flush_pending_o !== 1'b0) $display("[TB] FAIL fis_pend_clr: got %0h want 0", flush_pending_o); else pass_cnt++;
    cycle();
    check_cnt++; if ({valid_o, ctrl_o} !== {1'b1, 8'h90})
      $display("[TB] FAIL fis_single_bubble: got %0h want %0h", {valid_o, ctrl_o}, {1'b1, 8'h90}); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    load_instr(8'h44, 32'hCAFE, 32'h1, 5'd6, 5'd7, 5'd8);
    cycle();
    stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    check_cnt++; if (flush_pending_o !== 1'b1) $display("[TB] FAIL ar_pend_pre: got %0h want 1", flush_pending_o); else pass_cnt++;
    #2 rst_i = 1'b0;
    #1;
    check_cnt++; if ({valid_o, ctrl_o, rs1_data_o, rd_addr_o} !== 46'h0)
      $display("[TB] FAIL ar_outputs: got %0h want 0", {valid_o, ctrl_o, rs1_data_o, rd_addr_o}); else pass_cnt++;
    check_cnt++; if (flush_pending_o !== 1'b0) $display("[TB] FAIL ar_pend: got %0h want 0", flush_pending_o); else pass_cnt++;
`ifdef ID_EX_PERF_CNT_EN
    check_cnt++; if ({bubble_cnt_o, stall_cnt_o} !== 32'h0)
      $display("[TB] FAIL ar_counters: got %0h want 0", {bubble_cnt_o, stall_cnt_o}); else pass_cnt++;
`endif
    cycle();
    rst_i = 1'b1; stall_i = 1'b0;
    cycle();
    check_cnt++; if ({valid_o, ctrl_o} !== {1'b1, 8'h44})
      $display("[TB] FAIL ar_no_stale_flush: got %0h want %0h", {valid_o, ctrl_o}, {1'b1, 8'h44}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_plain_flush();
    test_capture();
    test_bypass();
    test_stall_hold();
    test_flush_in_stall();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
